// File: rtl/ibram_fetch.sv
// Instruction fetch stage in front of the instruction BRAM.
// Issues 64-bit aligned sequential reads and absorbs the 1-cycle RAM latency.
// Returned words go to decode as 2-slot packets through a 2-entry FIFO.
// A landing read bypasses the FIFO when the FIFO is empty, so a redirect
// reaches decode two cycles after it is taken.
module ibram_fetch #(
    parameter int          SIZE     = 8192,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         AW       = $clog2(SIZE) - 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic          pkt_valid,
    input  logic          pkt_ready,
    output logic [63:0]   pkt_data,
    output logic [31:0]   pkt_pc,
    output logic [1:0]    pkt_mask
);

    // One buffered packet; pc holds bits [31:3] of the packet address.
    typedef struct packed {
        logic [63:0] data;
        logic [28:0] pc;
        logic [1:0]  mask;
    } pkt_t;

    // fetch_pc[31:3] plus the half-word flag that stands in for fetch_pc[2]
    logic [28:0] pc_q;
    logic        first_half_q;

    // read issued last cycle; its data is on rd_data this cycle
    logic        inflight_q;
    logic [28:0] tag_pc_q;
    logic [1:0]  tag_mask_q;

    // output FIFO
    pkt_t        fifo_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  occ_q;

    logic        fifo_nempty;
    logic        bypass;
    logic        pop;
    logic        pop_fifo;
    logic        push;
    logic        credit_ok;
    pkt_t        landing;
    pkt_t        head;

    // redirect_pc[1:0] carries no information for an aligned fetch
    logic        unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign fifo_nempty = (occ_q != 2'd0);
    // data landing in a redirect cycle belongs to the old path and is never shown
    assign bypass      = ~fifo_nempty & inflight_q & ~redirect_valid;
    assign pkt_valid   = fifo_nempty | bypass;
    assign pop         = pkt_valid & pkt_ready;
    assign pop_fifo    = pop & fifo_nempty;
    // a landing read goes into the FIFO unless decode took it straight off rd_data
    assign push        = inflight_q & ~(pop & ~fifo_nempty);

    // free slots = 2 - occ - inflight + pop; every issued read owns one slot
    assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign rd_en     = fetch_en & ~redirect_valid & ~rst & credit_ok;
    assign rd_addr   = pc_q[AW-1:0];

    assign landing = '{data: rd_data, pc: tag_pc_q, mask: tag_mask_q};
    assign head    = fifo_nempty ? fifo_q[rd_ptr_q] : landing;

    // present the head packet, zeros when nothing is valid
    always_comb begin
        pkt_data = '0;
        pkt_pc   = '0;
        pkt_mask = '0;
        if (pkt_valid) begin
            pkt_data = head.data;
            pkt_pc   = {head.pc, 3'b000};
            pkt_mask = head.mask;
        end
    end

    // fetch PC, in-flight tracking and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC[31:3];
            first_half_q <= RESET_PC[2];
            inflight_q   <= 1'b0;
            tag_pc_q     <= '0;
            tag_mask_q   <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_pc[31:3];
            first_half_q <= redirect_pc[2];
            inflight_q   <= 1'b0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                tag_pc_q     <= pc_q;
                tag_mask_q   <= first_half_q ? 2'b10 : 2'b11;
                pc_q         <= pc_q + 29'd1;
                first_half_q <= 1'b0;
            end
            wr_ptr_q <= wr_ptr_q + push;
            rd_ptr_q <= rd_ptr_q + pop_fifo;
            occ_q    <= occ_q + {1'b0, push} - {1'b0, pop_fifo};
        end
    end

    // FIFO storage; contents are meaningless unless covered by occ
    always_ff @(posedge clk) begin
        if (push & ~rst & ~redirect_valid)
            fifo_q[wr_ptr_q] <= landing;
    end

endmodule
